// File: rtl/lcd_bus_rx.sv
// LCD-side receiver for an HD44780-style 8-bit parallel bus: synchronises rs/en/data,
// qualifies each strobe's setup and width, and queues {rs,data} words behind ready/valid.
module lcd_bus_rx #(
  parameter int SYNC_STAGES     = 2,
  parameter int EN_MIN_HIGH_CYC = 23,
  parameter int SETUP_MIN_CYC   = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rs_i,
  input  logic       en_i,
  input  logic [7:0] lcd_data_i,
  output logic [8:0] data_o,
  output logic       data_valid_o,
  input  logic       device_ready_i,
  output logic       timing_err_o,
  output logic       overflow_o
);

  localparam int SW = $clog2(SETUP_MIN_CYC + 1);
  localparam int HW = $clog2(EN_MIN_HIGH_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0] SETUP_LIM = SW'(SETUP_MIN_CYC);
  localparam logic [HW-1:0] HIGH_LIM  = HW'(EN_MIN_HIGH_CYC);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_WAIT_LOW,
    S_IDLE,
    S_STROBE
  } state_t;

  logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0][8:0] bus_sync_q, bus_sync_d;
  logic                        en_s;
  logic [8:0]                  bus_s;
  logic [SW-1:0]               stab_cnt_q, stab_cnt_d;

  state_t        state_q, state_d;
  logic          bad_q, bad_d;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic [8:0]    lat_q, lat_d;
  logic          push_q, push_d;
  logic [8:0]    push_word_q, push_word_d;
  logic          terr_q, terr_d;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop, full, wr_en;

  // Synchroniser chains; stability is judged by comparing the last two stages, so
  // stab_cnt equals the number of cycles bus_s has already held its current value.
  always_comb begin
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], en_i};
    bus_sync_d = {bus_sync_q[SYNC_STAGES-2:0], {rs_i, lcd_data_i}};
    en_s       = en_sync_q[SYNC_STAGES-1];
    bus_s      = bus_sync_q[SYNC_STAGES-1];
    stab_cnt_d = stab_cnt_q;
    if (bus_sync_q[SYNC_STAGES-2] != bus_s) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != SETUP_LIM) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    hi_cnt_d    = hi_cnt_q;
    lat_d       = lat_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    terr_d      = 1'b0;
    case (state_q)
      S_WAIT_LOW: begin
        if (!en_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (en_s) begin
          state_d  = S_STROBE;
          bad_d    = (stab_cnt_q < SETUP_LIM);
          hi_cnt_d = HW'(1);
          lat_d    = bus_s;
        end
      end
      S_STROBE: begin
        if (en_s) begin
          bad_d = bad_q | (bus_s != lat_q);
          if (hi_cnt_q != HIGH_LIM) hi_cnt_d = hi_cnt_q + 1'b1;
        end else begin
          state_d = S_IDLE;
          if (bad_q || (hi_cnt_q < HIGH_LIM)) begin
            terr_d = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_word_d = lat_q;
          end
        end
      end
      default: state_d = S_WAIT_LOW;
    endcase
  end

  // A push into a full FIFO still lands if the head leaves in the same cycle.
  always_comb begin
    pop        = (count_q != '0) && device_ready_i;
    full       = (count_q == FULL_CNT);
    wr_en      = push_q && (!full || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (push_q && full && !pop);
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_sync_q   <= '1;
      bus_sync_q  <= '0;
      stab_cnt_q  <= '0;
      state_q     <= S_WAIT_LOW;
      bad_q       <= 1'b0;
      hi_cnt_q    <= '0;
      lat_q       <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      terr_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      en_sync_q   <= en_sync_d;
      bus_sync_q  <= bus_sync_d;
      stab_cnt_q  <= stab_cnt_d;
      state_q     <= state_d;
      bad_q       <= bad_d;
      hi_cnt_q    <= hi_cnt_d;
      lat_q       <= lat_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      terr_q      <= terr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word_q;
  end

  always_comb begin
    data_valid_o = (count_q != '0);
    data_o       = data_valid_o ? mem_q[rd_ptr_q] : 9'h000;
    timing_err_o = terr_q;
    overflow_o   = overflow_q;
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Bench for lcd_bus_rx: directed scenarios plus randomized strobes, judged against
// a transaction-level model of which strobes are legal and what the consumer sees.
module tb_lcd_bus_rx;

  localparam int SYNC_STAGES = 2;
  localparam int EN_MIN      = 23;
  localparam int SETUP_MIN   = 4;
  localparam int DEPTH       = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs_i = 1'b0;
  logic       en_i = 1'b0;
  logic [7:0] d_i = 8'h00;
  logic       ready = 1'b0;
  logic [8:0] data_o;
  logic       valid;
  logic       terr;
  logic       ovf;

  always #5 clk = ~clk;

  lcd_bus_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .EN_MIN_HIGH_CYC(EN_MIN),
    .SETUP_MIN_CYC(SETUP_MIN),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rs_i(rs_i),
    .en_i(en_i),
    .lcd_data_i(d_i),
    .data_o(data_o),
    .data_valid_o(valid),
    .device_ready_i(ready),
    .timing_err_o(terr),
    .overflow_o(ovf)
  );

  int n_checks = 0;
  int n_err = 0;
  int terr_cnt = 0;
  int terr_long = 0;
  logic terr_prev = 1'b0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  // Consumer-side observer: every accepted beat and every error pulse.
  always @(negedge clk) begin
    if (valid && ready) got.push_back(data_o);
    if (terr) terr_cnt <= terr_cnt + 1;
    if (terr && terr_prev) terr_long <= terr_long + 1;
    terr_prev <= terr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one strobe; legality follows directly from the bus rules.
  task automatic strobe(input logic [8:0] w, input int setup, input int high,
                        input bit mid, output bit good);
    rs_i = w[8];
    d_i  = w[7:0];
    tick(setup);
    en_i = 1'b1;
    if (mid) begin
      tick(high / 2);
      d_i = d_i ^ 8'h01;
      tick(high - high / 2);
    end else begin
      tick(high);
    end
    en_i = 1'b0;
    good = (setup >= SETUP_MIN) && (high >= EN_MIN) && !mid;
    tick(8);
  endtask

  task automatic compare_drained(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_word"}, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    bit good;
    int lat;
    int t0;
    logic [8:0] w;
    int setup, high;
    bit mid;

    // Reset state
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_data", data_o, 0);
    check("rst_terr", terr, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick(3);

    // 1: single legal word, latency from pin fall
    ready = 1'b1;
    rs_i = 1'b0;
    d_i = 8'h38;
    tick(10);
    en_i = 1'b1;
    tick(30);
    en_i = 1'b0;
    lat = 0;
    while (!valid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("t1_latency", lat, SYNC_STAGES + 2);
    check("t1_data", data_o, 9'h038);
    tick(1);
    check("t1_one_beat", valid, 0);
    check("t1_terr", terr_cnt, 0);
    exp_q.push_back(9'h038);
    compare_drained("t1");

    // 2: five words into a four-deep FIFO with the consumer stalled
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(9'h141 + 9'(i), 10, 30, 1'b0, good);
      if (good && i < DEPTH) exp_q.push_back(9'h141 + 9'(i));
    end
    check("t2_valid", valid, 1);
    check("t2_head", data_o, 9'h141);
    tick(5);
    check("t2_head_held", data_o, 9'h141);
    check("t2_ovf", ovf, 1);
    ready = 1'b1;
    tick(DEPTH + 4);
    check("t2_empty", valid, 0);
    compare_drained("t2");

    // 3/4: rejected strobes and the exact legality boundaries
    t0 = terr_cnt;
    strobe(9'h0AA, 10, 10, 1'b0, good);
    check("t3_terr", terr_cnt - t0, 1);
    check("t3_pulse_len", terr_long, 0);
    strobe(9'h030, 10, 30, 1'b1, good);
    strobe(9'h052, 2, 30, 1'b0, good);
    check("t4_terr", terr_cnt - t0, 3);
    strobe(9'h060, 10, EN_MIN - 1, 1'b0, good);
    strobe(9'h061, SETUP_MIN - 1, 30, 1'b0, good);
    check("t4_bound_terr", terr_cnt - t0, 5);
    check("t4_no_word", got.size(), 0);
    strobe(9'h062, 10, EN_MIN, 1'b0, good);
    strobe(9'h063, SETUP_MIN, 30, 1'b0, good);
    check("t4_bound_ok_terr", terr_cnt - t0, 5);
    check("t3_pulse_len_all", terr_long, 0);
    exp_q.push_back(9'h062);
    exp_q.push_back(9'h063);
    compare_drained("t4");

    // 5: reset with a word queued and a strobe in flight
    ready = 1'b0;
    strobe(9'h077, 10, 30, 1'b0, good);
    check("t5_pre_valid", valid, 1);
    rs_i = 1'b0;
    d_i = 8'h55;
    tick(10);
    en_i = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", valid, 0);
    check("t5_ovf_cleared", ovf, 0);
    tick(3);
    rst_n = 1'b1;
    t0 = terr_cnt;
    tick(10);
    en_i = 1'b0;
    tick(10);
    check("t5_no_valid", valid, 0);
    check("t5_no_err", terr_cnt - t0, 0);
    ready = 1'b1;
    strobe(9'h001, 10, 30, 1'b0, good);
    exp_q.push_back(9'h001);
    compare_drained("t5");

    // 6: push into a full FIFO on the same cycle as a pop
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      strobe(9'h0A0 + 9'(i), 10, 30, 1'b0, good);
      exp_q.push_back(9'h0A0 + 9'(i));
    end
    rs_i = 1'b0;
    d_i = 8'hA4;
    tick(10);
    en_i = 1'b1;
    tick(30);
    en_i = 1'b0;
    tick(SYNC_STAGES + 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(6);
    exp_q.push_back(9'h0A4);
    check("t6_ovf", ovf, 0);
    check("t6_head", data_o, 9'h0A1);
    ready = 1'b1;
    tick(DEPTH + 4);
    check("t6_ovf_after", ovf, 0);
    compare_drained("t6");

    // Randomized strobes, consumer always ready
    for (int k = 0; k < 16; k++) begin
      w = 9'($urandom_range(0, 511));
      if (w == {rs_i, d_i}) w = w ^ 9'h001;
      setup = ($urandom_range(0, 3) == 0) ? $urandom_range(1, SETUP_MIN - 1)
                                          : $urandom_range(SETUP_MIN, 12);
      high = ($urandom_range(0, 3) == 0) ? $urandom_range(5, EN_MIN - 1)
                                         : $urandom_range(EN_MIN, 40);
      mid = ($urandom_range(0, 5) == 0);
      t0 = terr_cnt;
      strobe(w, setup, high, mid, good);
      check("rnd_terr", terr_cnt - t0, good ? 0 : 1);
      if (good) exp_q.push_back(w);
      compare_drained("rnd");
    end
    check("rnd_pulse_len", terr_long, 0);
    check("final_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
